// File: rtl/fp_normalizer.sv
// Sequential post-add normalizer for the single-precision FP adder.
// Shifts the raw sum mantissa one bit per cycle until the hidden bit is set, with handshakes on both sides.
module fp_normalizer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [7:0]  exp_in,
    input  logic [24:0] frac_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign_out,
    output logic [7:0]  exp_out,
    output logic [22:0] frac_out,
    output logic        ovf,
    output logic        udf,
    output logic        zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [24:0] mant_q, mant_d;
    logic [8:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic [7:0]  exp_out_q, exp_out_d;
    logic [22:0] frac_out_q, frac_out_d;
    logic        ovf_q, ovf_d;
    logic        udf_q, udf_d;
    logic        zero_q, zero_d;
    logic [8:0]  exp_inc;

    assign exp_inc = exp_q + 9'd1;

    always_comb begin
        state_d    = state_q;
        mant_d     = mant_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        exp_out_d  = exp_out_q;
        frac_out_d = frac_out_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        zero_d     = zero_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = sign_in;
                    mant_d = frac_in;
                    exp_d  = (exp_in == 8'd0) ? 9'd1 : {1'b0, exp_in};
                    ovf_d  = 1'b0;
                    udf_d  = 1'b0;
                    zero_d = 1'b0;
                    if (exp_in == 8'hFF) begin
                        exp_out_d  = 8'hFF;
                        frac_out_d = '0;
                        ovf_d      = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                if (mant_q == '0) begin
                    exp_out_d  = '0;
                    frac_out_d = '0;
                    zero_d     = 1'b1;
                    state_d    = DONE;
                end else if (mant_q[24]) begin
                    mant_d = {1'b0, mant_q[24:1]};
                    exp_d  = exp_inc;
                    if (exp_inc == 9'd255) begin
                        exp_out_d  = 8'hFF;
                        frac_out_d = '0;
                        ovf_d      = 1'b1;
                        state_d    = DONE;
                    end
                end else if (mant_q[23]) begin
                    exp_out_d  = exp_q[7:0];
                    frac_out_d = mant_q[22:0];
                    state_d    = DONE;
                end else if (exp_q == 9'd1) begin
                    // exponent floor reached: emit as denormal without further shifting
                    exp_out_d  = '0;
                    frac_out_d = mant_q[22:0];
                    udf_d      = 1'b1;
                    state_d    = DONE;
                end else begin
                    mant_d = {mant_q[23:0], 1'b0};
                    exp_d  = exp_q - 9'd1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mant_q     <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            exp_out_q  <= '0;
            frac_out_q <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mant_q     <= mant_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            exp_out_q  <= exp_out_d;
            frac_out_q <= frac_out_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            zero_q     <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign sign_out  = sign_q;
    assign exp_out   = exp_out_q;
    assign frac_out  = frac_out_q;
    assign ovf       = ovf_q;
    assign udf       = udf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed and random checks of fp_normalizer against a leading-one based reference model.
module tb_fp_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [24:0] frac_in;
    logic        out_valid;
    logic        out_ready;
    logic        sign_out;
    logic [7:0]  exp_out;
    logic [22:0] frac_out;
    logic        ovf;
    logic        udf;
    logic        zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        logic        o;
        logic        u;
        logic        z;
        int          lat;
    } exp_t;

    exp_t sb[$];

    fp_normalizer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .exp_in(exp_in), .frac_in(frac_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_out(sign_out), .exp_out(exp_out), .frac_out(frac_out),
        .ovf(ovf), .udf(udf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Latency counts from the accepting edge: 1 means out_valid visible right after it.
    function automatic exp_t model(input logic s, input logic [7:0] e_in, input logic [24:0] m);
        exp_t r;
        int e, p, k, sh;
        logic [24:0] mm;
        r.s = s; r.e = '0; r.f = '0; r.o = 0; r.u = 0; r.z = 0; r.lat = 0;
        if (e_in == 8'hFF) begin
            r.e = 8'hFF; r.o = 1; r.lat = 1;
        end else if (m == '0) begin
            r.z = 1; r.lat = 2;
        end else begin
            e = (e_in == 0) ? 1 : int'(e_in);
            if (m[24]) begin
                e = e + 1;
                if (e == 255) begin
                    r.e = 8'hFF; r.o = 1; r.lat = 2;
                end else begin
                    r.e = 8'(e); r.f = m[23:1]; r.lat = 3;
                end
            end else begin
                p = 0;
                for (int i = 0; i <= 23; i++) if (m[i]) p = i;
                k = 23 - p;
                if (e - k >= 1) begin
                    mm = m << k;
                    r.e = 8'(e - k); r.f = mm[22:0]; r.lat = 2 + k;
                end else begin
                    sh = e - 1;
                    mm = m << sh;
                    r.f = mm[22:0]; r.u = 1; r.lat = 2 + sh;
                end
            end
        end
        return r;
    endfunction

    task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] m, input int hold);
        exp_t x;
        int c;
        bit seen;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        sign_in = s; exp_in = e; frac_in = m; in_valid = 1'b1;
        sb.push_back(model(s, e, m));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        c = 1;
        seen = 0;
        while (!seen && c <= 40) begin
            if (out_valid) seen = 1;
            else begin
                @(negedge clk);
                c++;
            end
        end
        x = sb.pop_front();
        check("timeout", seen, 1);
        if (seen) begin
            check("latency", c, x.lat);
            for (int h = 0; h <= hold; h++) begin
                check("sign", sign_out, x.s);
                check("exp", exp_out, x.e);
                check("frac", frac_out, x.f);
                check("flags", {ovf, udf, zero}, {x.o, x.u, x.z});
                check("busy_in_ready", in_ready, 0);
                check("hold_valid", out_valid, 1);
                if (h < hold) @(negedge clk);
            end
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            check("release_valid", out_valid, 0);
            check("release_in_ready", in_ready, 1);
        end
    endtask

    initial begin
        bit bad;
        logic [24:0] rm;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        sign_in = 1'b0; exp_in = '0; frac_in = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_data", {sign_out, exp_out, frac_out, ovf, udf, zero}, '0);
        rst = 1'b0;
        #1 check("post_rst_in_ready", in_ready, 1);

        run_op(1'b1, 8'h80, 25'h0C00000, 0);   // normalized
        run_op(1'b0, 8'h85, 25'h0100000, 0);   // cancellation
        run_op(1'b0, 8'h7F, 25'h1800000, 0);   // carry
        run_op(1'b1, 8'hFE, 25'h1000000, 0);   // carry to overflow
        run_op(1'b0, 8'hFF, 25'h0C00000, 0);   // exp_in at max
        run_op(1'b0, 8'h03, 25'h0040000, 0);   // underflow
        run_op(1'b1, 8'h40, 25'h0000000, 0);   // zero
        run_op(1'b0, 8'h00, 25'h0800001, 0);   // exp 0 treated as 1
        run_op(1'b0, 8'h40, 25'h0000001, 0);   // worst-case 23 shifts
        run_op(1'b0, 8'h01, 25'h0000005, 0);   // denormal at floor
        run_op(1'b1, 8'h91, 25'h0A5A5A5, 10);  // backpressure

        // reset in the middle of a 20-shift operation
        @(negedge clk);
        sign_in = 1'b0; exp_in = 8'h80; frac_in = 25'h0000008; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_data", {exp_out, frac_out}, '0);
        rst = 1'b0;
        #1 check("midrst_release_in_ready", in_ready, 1);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) bad = 1;
        end
        check("no_valid_after_abort", bad, 0);
        run_op(1'b1, 8'h80, 25'h0000008, 2);

        for (int n = 0; n < 25; n++) begin
            rm = 25'($urandom) >> $urandom_range(0, 24);
            if ($urandom_range(0, 9) == 0) rm = '0;
            run_op(1'($urandom), 8'($urandom), rm, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
